// File: rtl/wave_gen_pkg.sv
// Shared modes, FSM states and helpers for the parametrised wave generator.
// Imported by the phase counter and the top level.
package wave_gen_pkg;

  localparam logic [1:0] WAVE_SQR = 2'd0;
  localparam logic [1:0] WAVE_SAW = 2'd1;
  localparam logic [1:0] WAVE_TRI = 2'd2;
  localparam logic [1:0] WAVE_DC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  localparam int PW = 32;

  // A zero peak would make a degenerate period, so it acts as 1.
  function automatic logic [PW-1:0] eff_peak(
    input logic [PW-1:0] p
  );
    return (p == '0) ? PW'(1) : p;
  endfunction

endpackage

// File: rtl/wave_gen_if.sv
// Control/sample bundle of the wave generator.
// The master drives the configuration, the slave returns samples.
interface wave_gen_if #(
  parameter int DW = 8,
  parameter int CW = 8
);
  logic          en;
  logic [1:0]    wave_sel;
  logic [CW-1:0] peak;
  logic [CW-1:0] duty;
  logic [DW-1:0] amp;
  logic [DW-1:0] wave;
  logic          cyc_start;
  logic [1:0]    mode_cur;

  modport master (
    output en, wave_sel, peak, duty, amp,
    input  wave, cyc_start, mode_cur
  );

  modport slave (
    input  en, wave_sel, peak, duty, amp,
    output wave, cyc_start, mode_cur
  );
endinterface

// File: rtl/wave_phase_cnt.sv
// Phase counter: IDLE/UP/DOWN FSM, count, and the config latch that
// only opens on the enable edge or at a period end.
import wave_gen_pkg::*;

module wave_phase_cnt #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    wave_sel,
  input  logic [CW-1:0] peak,
  input  logic [CW-1:0] duty,
  input  logic [DW-1:0] amp,
  output state_t        state,
  output logic [CW-1:0] cnt,
  output logic [1:0]    mode_a,
  output logic [CW-1:0] duty_a,
  output logic [DW-1:0] amp_a
);

  logic [CW-1:0] peak_a;
  logic [CW-1:0] peak_in;
  logic          dir;
  logic          tri_a;
  logic          at_peak;
  logic          per_end;
  logic          load;

  assign peak_in = CW'(eff_peak(PW'(peak)));
  assign dir     = (state == ST_DOWN);
  assign tri_a   = (mode_a == WAVE_TRI);
  assign at_peak = (cnt == peak_a);

  // Triangle with peak 1 has no down leg, so the top is the period end.
  always_comb begin
    per_end = 1'b0;
    unique case (1'b1)
      dir:
        per_end = (cnt == CW'(1));
      (state == ST_UP):
        per_end = at_peak &&
                  (!tri_a || peak_a == CW'(1));
      default:
        per_end = 1'b0;
    endcase
  end

  assign load = (state == ST_IDLE) ? en : per_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode_a <= WAVE_SQR;
      peak_a <= '0;
      duty_a <= '0;
      amp_a  <= '0;
    end else begin
      if (load) begin
        mode_a <= wave_sel;
        peak_a <= peak_in;
        duty_a <= duty;
        amp_a  <= amp;
      end
      unique case (state)
        ST_IDLE: begin
          if (en) begin
            state <= ST_UP;
            cnt   <= '0;
          end
        end
        ST_UP, ST_DOWN: begin
          if (!en) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (per_end) begin
            state <= ST_UP;
            cnt   <= '0;
          end else if (dir) begin
            cnt <= cnt - CW'(1);
          end else if (tri_a && at_peak) begin
            state <= ST_DOWN;
            cnt   <= peak_a - CW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/wave_gen_param.sv
// Multi-mode waveform generator top: sample mux and output registers
// around the phase counter.
import wave_gen_pkg::*;

module wave_gen_param #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input logic       clk,
  input logic       rst_n,
  wave_gen_if.slave bus
);

  if (CW < 2 || CW > DW) begin : g_bad_cw
    $error("wave_gen_param: CW must be in 2..DW");
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    mode_a;
  logic [CW-1:0] duty_a;
  logic [DW-1:0] amp_a;
  logic [DW-1:0] samp;
  logic [DW-1:0] wave_q;
  logic          cyc_q;
  logic [1:0]    mode_q;

  wave_phase_cnt #(
    .DW(DW),
    .CW(CW)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .wave_sel (bus.wave_sel),
    .peak     (bus.peak),
    .duty     (bus.duty),
    .amp      (bus.amp),
    .state    (state),
    .cnt      (cnt),
    .mode_a   (mode_a),
    .duty_a   (duty_a),
    .amp_a    (amp_a)
  );

  always_comb begin
    samp = '0;
    unique case (mode_a)
      WAVE_SQR: samp = (cnt < duty_a) ? amp_a : '0;
      WAVE_SAW: samp = DW'(cnt);
      WAVE_TRI: samp = DW'(cnt);
      WAVE_DC:  samp = amp_a;
      default:  samp = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_q <= '0;
      cyc_q  <= 1'b0;
      mode_q <= WAVE_SQR;
    end else begin
      wave_q <= (state != ST_IDLE) ? samp : '0;
      cyc_q  <= (state == ST_UP) && (cnt == '0);
      mode_q <= mode_a;
    end
  end

  assign bus.wave      = wave_q;
  assign bus.cyc_start = cyc_q;
  assign bus.mode_cur  = mode_q;

endmodule

// File: tb/tb_wave_gen_param.sv
// Randomised bench for wave_gen_param against a per-period sample-list
// model, plus directed sequences with literal expectations.
module tb_wave_gen_param;
  import wave_gen_pkg::*;

  localparam int DW = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wave_gen_if #(.DW(DW), .CW(CW)) bus ();

  wave_gen_param #(.DW(DW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  // model: list of samples for the running period and a position in it
  bit m_run = 0;
  int m_mode = 0;
  int seq[$];
  int pos = 0;
  int ew = 0, ec = 0, em = 0;
  int qw[$], qc[$], qm[$];

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic build_seq(input int mode, input int pk, input int dt,
                           input int am, output int q[$]);
    int p;
    p = (pk == 0) ? 1 : pk;
    q = {};
    for (int i = 0; i <= p; i++) begin
      case (mode)
        0: q.push_back(i < dt ? am : 0);
        1: q.push_back(i);
        2: q.push_back(i);
        default: q.push_back(am);
      endcase
    end
    if (mode == 2)
      for (int i = p - 1; i >= 1; i--) q.push_back(i);
  endtask

  task automatic load_cfg();
    m_mode = int'(bus.wave_sel);
    build_seq(m_mode, int'(bus.peak), int'(bus.duty),
              int'(bus.amp), seq);
  endtask

  // Predict the outputs after the coming edge, then advance the model.
  task automatic model_edge();
    bit at_end;
    if (!rst_n) begin
      ew = 0; ec = 0; em = 0;
      m_run = 0; m_mode = 0; seq = {}; pos = 0;
      return;
    end
    ew = m_run ? seq[pos] : 0;
    ec = (m_run && pos == 0) ? 1 : 0;
    em = m_mode;
    if (m_run) begin
      at_end = (pos == seq.size() - 1);
      if (at_end) load_cfg();
      if (!bus.en) m_run = 0;
      else if (at_end) pos = 0;
      else pos++;
    end else if (bus.en) begin
      load_cfg();
      pos = 0;
      m_run = 1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    chk("wave", int'(bus.wave), ew);
    chk("cyc_start", int'(bus.cyc_start), ec);
    chk("mode_cur", int'(bus.mode_cur), em);
    qw.push_back(int'(bus.wave));
    qc.push_back(int'(bus.cyc_start));
    qm.push_back(int'(bus.mode_cur));
  endtask

  task automatic run(input int n);
    qw = {}; qc = {}; qm = {};
    repeat (n) tick();
  endtask

  task automatic expect_q(input string nm, input int q[$],
                          input int e[$]);
    for (int i = 0; i < e.size(); i++)
      chk($sformatf("%s[%0d]", nm, i),
          (i < q.size()) ? q[i] : -1, e[i]);
  endtask

  task automatic cfg(input int ws, input int pk, input int dt,
                     input int am);
    bus.wave_sel = 2'(ws);
    bus.peak     = CW'(pk);
    bus.duty     = CW'(dt);
    bus.amp      = DW'(am);
  endtask

  task automatic idle();
    bus.en = 1'b0;
    run(2);
  endtask

  task automatic areset();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wave", int'(bus.wave), 0);
    chk("arst_cyc", int'(bus.cyc_start), 0);
    chk("arst_mode", int'(bus.mode_cur), 0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int q[$];
    bus.en = 1'b0;
    cfg(0, 0, 0, 0);

    build_seq(2, 3, 0, 0, q);
    expect_q("pin_tri3", q, '{0, 1, 2, 3, 2, 1});
    chk("pin_tri3_len", q.size(), 6);
    build_seq(0, 4, 2, 165, q);
    expect_q("pin_sqr", q, '{165, 165, 0, 0, 0});
    build_seq(2, 0, 0, 0, q);
    expect_q("pin_tri0", q, '{0, 1});

    @(negedge clk);
    chk("rst_wave", int'(bus.wave), 0);
    chk("rst_cyc", int'(bus.cyc_start), 0);
    chk("rst_mode", int'(bus.mode_cur), 0);
    rst_n = 1'b1;

    cfg(1, 3, 0, 0);
    bus.en = 1'b1;
    run(8);
    expect_q("saw3_w", qw, '{0, 0, 1, 2, 3, 0, 1, 2});
    expect_q("saw3_c", qc, '{0, 1, 0, 0, 0, 1, 0, 0});

    idle();
    cfg(2, 3, 0, 0);
    bus.en = 1'b1;
    run(9);
    expect_q("tri3_w", qw, '{0, 0, 1, 2, 3, 2, 1, 0, 1});
    expect_q("tri3_c", qc, '{0, 1, 0, 0, 0, 0, 0, 1, 0});

    idle();
    cfg(2, 1, 0, 0);
    bus.en = 1'b1;
    run(6);
    expect_q("tri1_w", qw, '{0, 0, 1, 0, 1, 0});
    idle();
    cfg(2, 0, 0, 0);
    bus.en = 1'b1;
    run(6);
    expect_q("tri0_w", qw, '{0, 0, 1, 0, 1, 0});

    idle();
    cfg(0, 4, 2, 'hA5);
    bus.en = 1'b1;
    run(8);
    expect_q("sqr_w", qw, '{0, 165, 165, 0, 0, 0, 165, 165});
    idle();
    cfg(0, 4, 0, 'hA5);
    bus.en = 1'b1;
    run(7);
    expect_q("sqr_d0", qw, '{0, 0, 0, 0, 0, 0, 0});
    idle();
    cfg(0, 4, 7, 'hA5);
    bus.en = 1'b1;
    run(7);
    expect_q("sqr_d7", qw, '{0, 165, 165, 165, 165, 165, 165});

    idle();
    cfg(1, 5, 0, 0);
    bus.en = 1'b1;
    run(3);
    expect_q("sw_pre", qw, '{0, 0, 1});
    cfg(3, 5, 0, 'h3C);
    run(6);
    expect_q("sw_w", qw, '{2, 3, 4, 5, 60, 60});
    expect_q("sw_m", qm, '{1, 1, 1, 1, 3, 3});
    expect_q("sw_c", qc, '{0, 0, 0, 0, 1, 0});

    idle();
    cfg(2, 3, 0, 0);
    bus.en = 1'b1;
    run(5);
    bus.en = 1'b0;
    run(2);
    expect_q("drop_w", qw, '{2, 0});
    bus.en = 1'b1;
    run(3);
    expect_q("rest_w", qw, '{0, 0, 1});
    expect_q("rest_c", qc, '{0, 1, 0});

    idle();
    cfg(1, 5, 0, 0);
    bus.en = 1'b1;
    run(4);
    chk("pre_arst_w", int'(bus.wave), 2);
    bus.en = 1'b0;
    areset();
    run(3);
    expect_q("post_arst_w", qw, '{0, 0, 0});
    expect_q("post_arst_m", qm, '{0, 0, 0});
    bus.en = 1'b1;
    run(3);
    expect_q("arst_go_w", qw, '{0, 0, 1});
    expect_q("arst_go_c", qc, '{0, 1, 0});

    for (int n = 0; n < 4000; n++) begin
      bus.en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 3) == 0)
        cfg($urandom_range(0, 3),
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255)
                                        : $urandom_range(0, 8),
            $urandom_range(0, 11),
            $urandom_range(0, 255));
      if ($urandom_range(0, 299) == 0) areset();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_gen_param.md
Name: wave_gen_param

Overview:
Parametrised multi-mode waveform generator, the successor to the fixed 5-bit square/saw/triangle generator. Generates square (programmable duty and amplitude), sawtooth, triangle and DC levels with run-time period, duty and amplitude. Mode and configuration changes take effect only at period boundaries, so the output never glitches mid-period. Feeds DAC-model and test-stimulus paths in the signal-processing datapath.

Parameters:
DW, 8, output sample width.
CW, 8, phase counter width; legal range 2 to DW, checked at elaboration.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
en  input  1  run enable; low forces IDLE
wave_sel  input  2  mode: 0 square, 1 sawtooth, 2 triangle, 3 DC
peak  input  CW  counter peak value; 0 is treated as 1
duty  input  CW  square-wave high phases per period
amp  input  DW  square high level and DC level
wave  output  DW  registered sample
cyc_start  output  1  high with the first sample of each period
mode_cur  output  2  active (latched) mode

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. Reset values: wave=0, cyc_start=0, mode_cur=0, state=IDLE, cnt=0, dir=up, active config=0.
- Active config registers (mode_a, peak_a=max(peak,1), duty_a, amp_a) load on the enable edge and on the period-end edge only. Input changes at any other time are ignored until the next boundary.
- States: IDLE, UP, DOWN.
- IDLE transition: if en=1, load config, cnt<=0, go to UP. Otherwise stay in IDLE.
- Square/saw/DC: UP only. cnt counts 0..peak_a, so the period is peak_a+1 cycles. At cnt==peak_a, cnt<=0 and config reloads (period end).
- Triangle up phase: UP counts 0..peak_a. At peak_a, go to DOWN with cnt<=peak_a-1. If peak_a==1 this is a period end instead: cnt<=0, stay UP.
- Triangle down phase: DOWN counts to 1. At cnt==1 this is a period end: cnt<=0, go to UP. The period is 2*peak_a cycles, with no repeated endpoints.
- Period end during triangle while the newly loaded mode is not triangle: next state is UP with cnt=0 regardless.
- en=0 in UP or DOWN: next edge goes to IDLE, cnt<=0. The partial period is abandoned.
- Sample function f:
  - square: amp_a if cnt<duty_a, else 0. duty_a=0 gives constant 0; duty_a>peak_a gives constant amp_a.
  - saw and triangle: cnt zero-extended to DW.
  - DC: amp_a.
- Output register: wave<=f(cnt, cfg) when state!=IDLE, else 0.
- Output register: cyc_start<=(state==UP && cnt==0 && state!=IDLE), registered with wave.
- Output register: mode_cur<=mode_a.
- Latency: en sampled high at edge k gives the first sample (cnt=0) on wave, with cyc_start=1, after edge k+1. wave always lags cnt by one cycle.
- Arithmetic: cnt is CW bits unsigned and never exceeds peak_a, so it cannot overflow. peak_a-1 is evaluated only when peak_a>=2.
- Simultaneous events: en falling at a period end: IDLE wins, and config still reloads.
- Reset mid-operation: immediate return to reset values. The first period after reset starts only on en.

Decomposition:
- Package wave_gen_pkg holds:
  - mode localparams WAVE_SQR=2'd0, WAVE_SAW=2'd1, WAVE_TRI=2'd2, WAVE_DC=2'd3;
  - state encodings ST_IDLE, ST_UP, ST_DOWN;
  - function eff_peak (maps 0 to 1).
- One sub-module, wave_phase_cnt, owns state, cnt, dir, the period-end strobe and the config latch. The top level holds the sample mux and the output registers.

Test Plan:
1. DW=8, CW=8, saw, peak=3, en high from reset -> wave 0,1,2,3,0,1,... with cyc_start on each 0; first sample 2 cycles after en.
2. Triangle, peak=3 -> wave 0,1,2,3,2,1,0,... period 6; peak=1 -> 0,1,0,1; peak=0 behaves identically to peak=1.
3. Square, peak=4, duty=2, amp=8'hA5 -> A5,A5,0,0,0 repeating; duty=0 -> all 0; duty=7 -> all A5.
4. Saw peak=5, switch wave_sel to DC amp=8'h3C at cnt=2 -> saw continues 3,4,5, then 3C from the next cyc_start; mode_cur changes the same cycle.
5. Drop en at triangle cnt=2 down -> wave=0 one cycle later; re-raise en -> restart at 0 with cyc_start.
6. Assert rst_n low asynchronously mid-period (between edges) -> wave, cyc_start and mode_cur go to 0 immediately without a clock edge; release -> IDLE until en.
